speed_gate_ctrl: RTL and testbench
==================================

Name: speed_gate_ctrl

Overview: Controller FSM that sequences the speed-measurement datapath at the vehicle gate. It detects sensor 1 then sensor 2 and drives the datapath init/count/cal strobes. It waits for the divider's done, compares speed against a limit, then opens the barrier for a hold time and closes it. It also owns timeout, overspeed and vehicle-count bookkeeping.

Parameters:
SYS_FREQ, 10000000, system clock in Hz; internal ms prescaler wraps at SYS_FREQ/1000-1.
WIDTH_SPEED, 14, width of the speed input from the datapath.
SPEED_LIMIT, 60, max allowed speed; speed <= limit passes.
TIMEOUT_MS, 3000, max ms between sensor 1 and sensor 2 edges.
HOLD_MS, 2000, barrier open time in ms.
DIV_GUARD, 64, max clocks to wait for done after cal.
WIDTH_VEH, 4, vehicle counter width.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
sen1  in  1  entry sensor, asynchronous, active-high
sen2  in  1  exit sensor, asynchronous, active-high
speed  in  WIDTH_SPEED  quotient from datapath
done  in  1  divider done pulse from datapath
init  out  1  one-cycle datapath clear strobe
count  out  1  level; datapath timebase runs while high
cal  out  1  one-cycle start-divide strobe
up  out  1  one-cycle vehicle-accepted strobe; opens barrier
down  out  1  one-cycle vehicle-cleared strobe
en  out  1  one-cycle barrier-open strobe
dis  out  1  one-cycle barrier-close strobe
overspeed  out  1  sticky flag; last vehicle exceeded limit
timeout  out  1  sticky flag; last measurement timed out or div guard expired
busy  out  1  high in any state except IDLE
num_veh  out  WIDTH_VEH  vehicles currently passing barrier

Behaviour:
- Reset: all outputs 0; state IDLE; sync flops, timers and counters 0. Reset takes effect immediately, mid-operation included; the barrier is not explicitly closed (datapath also resets).
- Input conditioning: sen1/sen2 each use a 2-flop synchronizer plus a previous-value register. The rise pulse is 1 cycle and fires 3 clocks after the input goes high. Held-high inputs give only one pulse.
- Internal ms tick: prescaler counts 0..SYS_FREQ/1000-1 and emits a tick on wrap. It is cleared on any state entry that starts a timer (COUNT, HOLD).
- States and transitions:
  - IDLE: sen1 rise -> INIT. sen2 rise ignored.
  - INIT (1 cycle): init=1 and timeout/overspeed cleared, then -> COUNT.
  - COUNT: count=1 each cycle.
    - sen2 rise -> CALC.
    - Else ms timer reaching TIMEOUT_MS -> IDLE with timeout set and init pulsed the same cycle.
    - sen1 rise is ignored.
    - sen2 rise wins over timeout in the same cycle.
  - CALC (1 cycle): cal=1, count=0, then -> WAIT_DONE.
  - WAIT_DONE: done -> JUDGE, latching speed the same cycle. A guard counter reaching DIV_GUARD clocks -> IDLE with timeout set.
  - JUDGE (1 cycle):
    - Latched speed == 0 is treated as invalid -> timeout set, -> IDLE.
    - speed > SPEED_LIMIT -> overspeed set, -> IDLE, barrier stays closed.
    - Else up=1 and en=1, num_veh +1 (saturating at all-ones), -> HOLD.
  - HOLD: ms timer reaching HOLD_MS -> CLOSE. sen1 rise is ignored while in HOLD.
  - CLOSE (1 cycle): dis=1 and down=1, num_veh -1 (floored at 0), -> IDLE.
- Strobes: init, cal, up, en, dis and down are high for exactly one clock per event. They are never asserted in IDLE except init on timeout exit.
- Flags: timeout and overspeed are sticky until the next INIT. busy = (state != IDLE).
- Latency: sen2 rise -> cal is 1 clock. done -> up/en is 1 clock. HOLD entry -> dis is HOLD_MS*SYS_FREQ/1000 clocks (±1).

Test Plan:
- SYS_FREQ=10000 (10 clk/ms). sen1 high, sen2 high 240 ms later, speed=60 on done -> init once, count high ~240 ms, cal 1 cycle, up+en next cycle after done, num_veh=1, dis+down after 2000 ms, num_veh=0.
- Same timing, speed=61 -> overspeed=1, no up/en/dis, busy drops 1 clock after done, num_veh unchanged.
- sen1 only, no sen2 -> at 3000 ms timeout=1, init pulse, state IDLE, count=0.
- cal issued, done never asserted -> after 64 clocks timeout=1, IDLE.
- Assert reset_n=0 mid-COUNT and mid-HOLD -> all outputs 0 immediately. After release, sen2 alone causes no activity; the next sen1 starts cleanly.
- sen2 rise and TIMEOUT_MS expiry in the same cycle -> CALC entered, timeout stays 0. sen1 held high for 5000 ms -> exactly one init.

Source files
------------

// File: rtl/speed_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : speed_gate_ctrl
// Purpose  : Vehicle-gate sequencer: sensor edges, datapath strobes, barrier.
// Revision : 1.0  initial release
// ============================================================================
module speed_gate_ctrl #(
  parameter int SYS_FREQ    = 10000000,
  parameter int WIDTH_SPEED = 14,
  parameter int SPEED_LIMIT = 60,
  parameter int TIMEOUT_MS  = 3000,
  parameter int HOLD_MS     = 2000,
  parameter int DIV_GUARD   = 64,
  parameter int WIDTH_VEH   = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sen1,
  input  logic                   sen2,
  input  logic [WIDTH_SPEED-1:0] speed,
  input  logic                   done,
  output logic                   init,
  output logic                   count,
  output logic                   cal,
  output logic                   up,
  output logic                   down,
  output logic                   en,
  output logic                   dis,
  output logic                   overspeed,
  output logic                   timeout,
  output logic                   busy,
  output logic [WIDTH_VEH-1:0]   num_veh
);

  localparam int PRE_MAX = SYS_FREQ / 1000 - 1;
  localparam int PRE_W   = (PRE_MAX > 0) ? $clog2(PRE_MAX + 1) : 1;
  localparam int MS_MAX  = (TIMEOUT_MS > HOLD_MS) ? TIMEOUT_MS : HOLD_MS;
  localparam int MS_W    = $clog2(MS_MAX + 1);
  localparam int GD_W    = $clog2(DIV_GUARD + 1);

  localparam logic [PRE_W-1:0]       c_pre_last   = PRE_W'(PRE_MAX);
  localparam logic [MS_W-1:0]        c_ms_top     = MS_W'(MS_MAX);
  localparam logic [MS_W-1:0]        c_ms_timeout = MS_W'(TIMEOUT_MS - 1);
  localparam logic [MS_W-1:0]        c_ms_hold    = MS_W'(HOLD_MS - 1);
  localparam logic [GD_W-1:0]        c_guard_last = GD_W'(DIV_GUARD - 1);
  localparam logic [WIDTH_SPEED-1:0] c_limit      = WIDTH_SPEED'(SPEED_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_COUNT = 3'd2,
    S_CALC  = 3'd3,
    S_WAIT  = 3'd4,
    S_JUDGE = 3'd5,
    S_HOLD  = 3'd6,
    S_CLOSE = 3'd7
  } state_t;

  state_t                 r_state;
  logic                   r_s1_meta, r_s1_sync, r_s1_prev;
  logic                   r_s2_meta, r_s2_sync, r_s2_prev;
  logic [PRE_W-1:0]       r_pre;
  logic [MS_W-1:0]        r_ms;
  logic [GD_W-1:0]        r_guard;
  logic [WIDTH_SPEED-1:0] r_speed;
  logic                   r_init, r_count, r_cal, r_up, r_down, r_en, r_dis;
  logic                   r_overspeed, r_timeout;
  logic [WIDTH_VEH-1:0]   r_num_veh;
  logic                   w_s1_rise, w_s2_rise, w_tick;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {r_s1_meta, r_s1_sync, r_s1_prev} <= 3'b000;
      {r_s2_meta, r_s2_sync, r_s2_prev} <= 3'b000;
    end else begin
      {r_s1_meta, r_s1_sync, r_s1_prev} <= {sen1, r_s1_meta, r_s1_sync};
      {r_s2_meta, r_s2_sync, r_s2_prev} <= {sen2, r_s2_meta, r_s2_sync};
    end
  end

  assign w_s1_rise = r_s1_sync & ~r_s1_prev;
  assign w_s2_rise = r_s2_sync & ~r_s2_prev;
  assign w_tick    = (r_pre == c_pre_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_pre       <= '0;
      r_ms        <= '0;
      r_guard     <= '0;
      r_speed     <= '0;
      r_init      <= 1'b0;
      r_count     <= 1'b0;
      r_cal       <= 1'b0;
      r_up        <= 1'b0;
      r_down      <= 1'b0;
      r_en        <= 1'b0;
      r_dis       <= 1'b0;
      r_overspeed <= 1'b0;
      r_timeout   <= 1'b0;
      r_num_veh   <= '0;
    end else begin
      r_init <= 1'b0;
      r_cal  <= 1'b0;
      r_up   <= 1'b0;
      r_en   <= 1'b0;
      r_dis  <= 1'b0;
      r_down <= 1'b0;
      r_pre  <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick && (r_ms != c_ms_top)) r_ms <= r_ms + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_s1_rise) begin
            r_state     <= S_INIT;
            r_init      <= 1'b1;
            r_timeout   <= 1'b0;
            r_overspeed <= 1'b0;
          end
        end
        S_INIT: begin
          r_state <= S_COUNT;
          r_count <= 1'b1;
          r_pre   <= '0;
          r_ms    <= '0;
        end
        S_COUNT: begin
          // Exit sensor takes priority over an expiry landing on the same cycle.
          if (w_s2_rise) begin
            r_state <= S_CALC;
            r_count <= 1'b0;
            r_cal   <= 1'b1;
          end else if (w_tick && (r_ms == c_ms_timeout)) begin
            r_state   <= S_IDLE;
            r_count   <= 1'b0;
            r_timeout <= 1'b1;
            r_init    <= 1'b1;
          end
        end
        S_CALC: begin
          r_state <= S_WAIT;
          r_guard <= '0;
        end
        S_WAIT: begin
          if (done) begin
            r_state <= S_JUDGE;
            r_speed <= speed;
          end else if (r_guard == c_guard_last) begin
            r_state   <= S_IDLE;
            r_timeout <= 1'b1;
          end else begin
            r_guard <= r_guard + 1'b1;
          end
        end
        S_JUDGE: begin
          if (r_speed == '0) begin
            r_state   <= S_IDLE;
            r_timeout <= 1'b1;
          end else if (r_speed > c_limit) begin
            r_state     <= S_IDLE;
            r_overspeed <= 1'b1;
          end else begin
            r_state <= S_HOLD;
            r_up    <= 1'b1;
            r_en    <= 1'b1;
            r_pre   <= '0;
            r_ms    <= '0;
            if (r_num_veh != '1) r_num_veh <= r_num_veh + 1'b1;
          end
        end
        S_HOLD: begin
          if (w_tick && (r_ms == c_ms_hold)) begin
            r_state <= S_CLOSE;
            r_dis   <= 1'b1;
            r_down  <= 1'b1;
            if (r_num_veh != '0) r_num_veh <= r_num_veh - 1'b1;
          end
        end
        S_CLOSE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign init      = r_init;
  assign count     = r_count;
  assign cal       = r_cal;
  assign up        = r_up;
  assign down      = r_down;
  assign en        = r_en;
  assign dis       = r_dis;
  assign overspeed = r_overspeed;
  assign timeout   = r_timeout;
  assign busy      = (r_state != S_IDLE);
  assign num_veh   = r_num_veh;

endmodule
`default_nettype wire

// File: tb/tb_speed_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_speed_gate_ctrl
// Purpose  : Randomised vehicle transactions against a timing-rule reference.
// Revision : 1.0  initial release
// ============================================================================
module tb_speed_gate_ctrl;

  localparam int SYS_FREQ = 10000;
  localparam int WS       = 14;
  localparam int LIM      = 60;
  localparam int TMS      = 30;
  localparam int HMS      = 20;
  localparam int GUARD    = 64;
  localparam int WV       = 4;
  localparam int CPM      = SYS_FREQ / 1000;

  logic          clk     = 1'b0;
  logic          reset_n = 1'b1;
  logic          sen1    = 1'b0;
  logic          sen2    = 1'b0;
  logic          done    = 1'b0;
  logic [WS-1:0] speed   = '0;
  logic          init, count, cal, up, down, en, dis, overspeed, timeout, busy;
  logic [WV-1:0] num_veh;

  speed_gate_ctrl #(
    .SYS_FREQ(SYS_FREQ), .WIDTH_SPEED(WS), .SPEED_LIMIT(LIM), .TIMEOUT_MS(TMS),
    .HOLD_MS(HMS), .DIV_GUARD(GUARD), .WIDTH_VEH(WV)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .sen1(sen1), .sen2(sen2), .speed(speed),
    .done(done), .init(init), .count(count), .cal(cal), .up(up), .down(down),
    .en(en), .dis(dis), .overspeed(overspeed), .timeout(timeout), .busy(busy),
    .num_veh(num_veh)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log sampled mid-cycle: running totals plus the cycle of the last event.
  int   n_init = 0, t_init = 0, n_cal = 0, t_cal = 0, n_up = 0, t_up = 0;
  int   n_en = 0, t_en = 0, n_dis = 0, t_dis = 0, n_down = 0, n_cnt = 0;
  int   n_busy = 0, n_fall = 0, t_fall = 0, nv_up = 0, nv_dis = 0;
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    if (init)  begin n_init++; t_init = cyc; end
    if (cal)   begin n_cal++;  t_cal  = cyc; end
    if (up)    begin n_up++;   t_up   = cyc; nv_up = int'(num_veh); end
    if (en)    begin n_en++;   t_en   = cyc; end
    if (dis)   begin n_dis++;  t_dis  = cyc; nv_dis = int'(num_veh); end
    if (down)  n_down++;
    if (count) n_cnt++;
    if (busy)  n_busy++;
    if (prev_busy && !busy) begin n_fall++; t_fall = cyc; end
    prev_busy = busy;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {18'd0, init, count, cal, up, down, en, dis, overspeed, timeout, busy, num_veh};
  endfunction

  // One vehicle: sen1 rises, sen2 rises gap cycles later, done pulses dly
  // cycles into the divide wait. Expected behaviour is derived from timing rules.
  task automatic vehicle(input int gap, input int spd, input int dly);
    int  n, m, d;
    int  b_init, b_cal, b_up, b_en, b_dis, b_down, b_cnt, b_fall;
    bit  calc, pass;
    int  exp_fall, exp_to, exp_os;
    b_init = n_init; b_cal = n_cal; b_up = n_up; b_en = n_en;
    b_dis = n_dis; b_down = n_down; b_cnt = n_cnt; b_fall = n_fall;

    tick(1); n = cyc; sen1 = 1'b1;
    tick(gap); m = cyc; sen2 = 1'b1;
    tick(4 + dly); d = cyc; speed = WS'(spd); done = 1'b1;
    tick(1); done = 1'b0;
    speed = (spd == 0 || spd > LIM) ? WS'(5) : WS'(999);
    while (cyc < n + CPM*TMS + CPM*HMS + 120) tick(1);
    sen1 = 1'b0; sen2 = 1'b0;
    tick(4);

    calc   = (gap <= CPM*TMS + 1);
    pass   = 1'b0;
    exp_to = 0;
    exp_os = 0;
    if (!calc) begin
      exp_to = 1; exp_fall = n + 4 + CPM*TMS;
    end else if (dly >= GUARD) begin
      exp_to = 1; exp_fall = m + 4 + GUARD;
    end else if (spd == 0) begin
      exp_to = 1; exp_fall = d + 2;
    end else if (spd > LIM) begin
      exp_os = 1; exp_fall = d + 2;
    end else begin
      pass = 1'b1; exp_fall = d + 3 + CPM*HMS;
    end

    check("init_count", n_init - b_init, calc ? 1 : 2);
    check("init_time", t_init, calc ? n + 3 : n + 4 + CPM*TMS);
    check("cal_count", n_cal - b_cal, calc ? 1 : 0);
    if (calc) check("cal_time", t_cal, m + 3);
    check("count_cycles", n_cnt - b_cnt, calc ? gap - 1 : CPM*TMS);
    check("up_count", n_up - b_up, pass ? 1 : 0);
    check("en_count", n_en - b_en, pass ? 1 : 0);
    check("dis_count", n_dis - b_dis, pass ? 1 : 0);
    check("down_count", n_down - b_down, pass ? 1 : 0);
    if (pass) begin
      check("up_time", t_up, d + 2);
      check("en_time", t_en, d + 2);
      check("dis_time", t_dis, d + 2 + CPM*HMS);
      check("nveh_open", nv_up, 1);
      check("nveh_close", nv_dis, 0);
    end
    check("busy_falls", n_fall - b_fall, 1);
    check("busy_fall_time", t_fall, exp_fall);
    check("timeout_flag", timeout, exp_to);
    check("overspeed_flag", overspeed, exp_os);
    check("nveh_end", num_veh, 0);
    check("busy_end", busy, 0);
  endtask

  initial begin
    #(4_000_000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int b;
    int spd, gap, dly, sel;
    #2 reset_n = 1'b0;
    tick(3);
    check("reset_outputs", outs(), 0);
    reset_n = 1'b1;
    tick(3);

    vehicle(24, 60, 5);
    vehicle(24, 61, 5);
    vehicle(CPM*TMS + 3, 30, 5);
    vehicle(20, 30, 100);
    vehicle(20, 30, GUARD - 1);
    vehicle(20, 30, GUARD);
    vehicle(CPM*TMS + 1, 30, 5);
    vehicle(CPM*TMS + 2, 30, 5);
    vehicle(20, 0, 3);

    for (int i = 0; i < 16; i++) begin
      gap = 2 + int'($urandom % (CPM*TMS + 4));
      dly = int'($urandom % 72);
      sel = int'($urandom % 6);
      case (sel)
        0:       spd = 0;
        1:       spd = LIM;
        2:       spd = LIM + 1;
        3:       spd = 1 + int'($urandom % LIM);
        default: spd = LIM + 1 + int'($urandom % 1000);
      endcase
      vehicle(gap, spd, dly);
    end

    tick(1); sen1 = 1'b1;
    tick(40);
    reset_n = 1'b0;
    #1;
    check("reset_mid_count", outs(), 0);
    sen1 = 1'b0;
    tick(2); reset_n = 1'b1; tick(3);

    tick(1); sen1 = 1'b1;
    tick(10); sen2 = 1'b1;
    tick(10); speed = WS'(30); done = 1'b1;
    tick(1); done = 1'b0;
    tick(50);
    check("hold_nveh", num_veh, 1);
    reset_n = 1'b0;
    #1;
    check("reset_mid_hold", outs(), 0);
    sen1 = 1'b0; sen2 = 1'b0;
    tick(2); reset_n = 1'b1; tick(3);

    b = n_busy;
    sen2 = 1'b1;
    tick(20);
    check("sen2_alone_busy", n_busy - b, 0);
    sen2 = 1'b0;
    tick(3);
    vehicle(24, 45, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
